spi_ch_reg_decoder: RTL and testbench

Serial SPI front-end that assembles the register address and data words from MOSI and decodes the address into channel index plus per-channel register index. It generalises the fixed 8-channel, 7-register, 3-bit select to parametrised channel count, registers per channel and widths. It adds burst auto-increment with optional per-channel wrap, and registered data-word strobes. It sits between the SPI pin interface and the per-channel timestamp/config register banks.

---
 rtl/spi_dec_pkg.sv | 19 +
 rtl/ch_addr_decode.sv | 42 ++++
 rtl/spi_ch_reg_decoder.sv | 149 ++++++++++++++
 tb/tb_spi_ch_reg_decoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dec_pkg.sv
// Shared constants, decoder state encoding and helpers for the SPI
// channel/register address decoder.
package spi_dec_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;
  localparam int WORD_CNT_W = 8;

  typedef enum logic {
    ST_ADDR = 1'b0,
    ST_DATA = 1'b1
  } dec_state_e;

  // All-ones marker meaning "no per-channel register selected".
  function automatic int reg_none(input int reg_w);
    return (1 << reg_w) - 1;
  endfunction

endpackage

// File: rtl/ch_addr_decode.sv
// Combinational split of a word address into channel index and register
// index inside the channel-based register window.
module ch_addr_decode
  import spi_dec_pkg::*;
#(
  parameter int ADDR_W            = DEF_ADDR_W,
  parameter int NUM_CH            = 8,
  parameter int REGS_PER_CH       = 7,
  parameter int CH_REG_START_ADDR = 12,
  parameter int CH_W              = 3,
  parameter int REG_W             = 3
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              in_range,
  output logic [CH_W-1:0]   ch_sel,
  output logic [REG_W-1:0]  reg_sel
);

  localparam int unsigned START_U = CH_REG_START_ADDR;
  localparam int unsigned STOP_U  = CH_REG_START_ADDR + NUM_CH * REGS_PER_CH - 1;
  localparam int unsigned RPC_U   = REGS_PER_CH;
  localparam logic [REG_W-1:0] REG_NONE = REG_W'(reg_none(REG_W));

  int unsigned addr_u;
  int unsigned offset;

  // Range check, then constant divide/modulo of the window offset.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    in_range = 1'b0;
    ch_sel   = '0;
    reg_sel  = REG_NONE;
    addr_u   = 32'(addr);
    offset   = addr_u - START_U;
    if (addr_u >= START_U && addr_u <= STOP_U) begin
      in_range = 1'b1;
      ch_sel   = CH_W'(offset / RPC_U);
      reg_sel  = REG_W'(offset % RPC_U);
    end
  end

endmodule

// File: rtl/spi_ch_reg_decoder.sv
// SPI front-end: shifts in an address then a stream of data words, decodes
// the address into channel/register and auto-increments between words.
module spi_ch_reg_decoder
  import spi_dec_pkg::*;
#(
  parameter int ADDR_W            = DEF_ADDR_W,
  parameter int DATA_W            = DEF_DATA_W,
  parameter int NUM_CH            = 8,
  parameter int REGS_PER_CH       = 7,
  parameter int CH_REG_START_ADDR = 12,
  parameter bit AUTO_INC          = 1'b1,
  parameter bit WRAP_CH           = 1'b0,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int REG_W = $clog2(REGS_PER_CH + 1)
) (
  input  logic                  spi_clk,
  input  logic                  full_rstn,
  input  logic                  mosi,
  output logic [ADDR_W-1:0]     addr_q,
  output logic [CH_W-1:0]       ch_sel,
  output logic [REG_W-1:0]      reg_sel,
  output logic                  in_ch_range,
  output logic [DATA_W-1:0]     data_word,
  output logic                  word_strobe,
  output logic [WORD_CNT_W-1:0] word_count
);

  localparam int SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int SHR_W = SH_W - 1;
  localparam int CNT_W = $clog2(SH_W);
  localparam int STOP  = CH_REG_START_ADDR + NUM_CH * REGS_PER_CH - 1;
  localparam logic [REG_W-1:0] REG_NONE  = REG_W'(reg_none(REG_W));
  localparam logic [REG_W-1:0] REG_LAST  = REG_W'(REGS_PER_CH - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  if (REGS_PER_CH < 1) begin : g_chk_regs
    $error("REGS_PER_CH must be at least 1");
  end
  if (NUM_CH < 1) begin : g_chk_ch
    $error("NUM_CH must be at least 1");
  end
  if (ADDR_W < 2 || ADDR_W > 30 || DATA_W < 2) begin : g_chk_w
    $error("ADDR_W must be 2..30 and DATA_W at least 2");
  end
  if (STOP >= (1 << ADDR_W)) begin : g_chk_stop
    $error("channel register window exceeds the address space");
  end

  dec_state_e        state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [SHR_W-1:0]  shreg;
  logic [ADDR_W-1:0] addr_new, addr_inc;
  logic [DATA_W-1:0] data_new;
  logic              addr_last, data_last;
  logic              new_in_range, inc_in_range;
  logic [CH_W-1:0]   new_ch, inc_ch;
  logic [REG_W-1:0]  new_reg, inc_reg;

  assign addr_new  = {shreg[ADDR_W-2:0], mosi};
  assign data_new  = {shreg[DATA_W-2:0], mosi};
  assign addr_last = (state == ST_ADDR) && (bit_cnt == ADDR_LAST);
  assign data_last = (state == ST_DATA) && (bit_cnt == DATA_LAST);

  // Next word address: plain wrap-around increment, or back to reg 0 of the
  // same channel when wrapping within a channel block.
  always_comb begin
    addr_inc = addr_q + ADDR_W'(1);
    if (WRAP_CH && in_ch_range && reg_sel == REG_LAST) begin
      addr_inc = addr_q - ADDR_W'(REGS_PER_CH - 1);
    end
  end

  ch_addr_decode #(
    .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .REGS_PER_CH(REGS_PER_CH),
    .CH_REG_START_ADDR(CH_REG_START_ADDR), .CH_W(CH_W), .REG_W(REG_W)
  ) u_dec_new (
    .addr(addr_new), .in_range(new_in_range), .ch_sel(new_ch), .reg_sel(new_reg)
  );

  ch_addr_decode #(
    .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .REGS_PER_CH(REGS_PER_CH),
    .CH_REG_START_ADDR(CH_REG_START_ADDR), .CH_W(CH_W), .REG_W(REG_W)
  ) u_dec_inc (
    .addr(addr_inc), .in_range(inc_in_range), .ch_sel(inc_ch), .reg_sel(inc_reg)
  );

  // Next state: address phase ends after its last bit; data phase is terminal.
  always_comb begin
    state_nxt = state;
    if (addr_last) state_nxt = ST_DATA;
  end

  // State register.
  always_ff @(posedge spi_clk or negedge full_rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!full_rstn) state <= ST_ADDR;
    else            state <= state_nxt;
  end

  // Serial shift register and bit position within the current field.
  always_ff @(posedge spi_clk or negedge full_rstn) begin
    // NOTE: the shift register is reset as well so a new transaction never sees stale bits.
    if (!full_rstn) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      shreg   <= SHR_W'({shreg, mosi});
      bit_cnt <= (addr_last || data_last) ? '0 : bit_cnt + CNT_W'(1);
    end
  end

  // Word address and its registered decode: loaded from the shifted address,
  // then advanced on the strobe cycle when auto-increment is enabled.
  always_ff @(posedge spi_clk or negedge full_rstn) begin
    if (!full_rstn) begin
      addr_q      <= '0;
      ch_sel      <= '0;
      reg_sel     <= REG_NONE;
      in_ch_range <= 1'b0;
    end else if (addr_last) begin
      addr_q      <= addr_new;
      ch_sel      <= new_ch;
      reg_sel     <= new_reg;
      in_ch_range <= new_in_range;
    end else if (AUTO_INC && word_strobe) begin
      addr_q      <= addr_inc;
      ch_sel      <= inc_ch;
      reg_sel     <= inc_reg;
      in_ch_range <= inc_in_range;
    end
  end

  // Completed data word, one-cycle strobe and saturating word counter.
  always_ff @(posedge spi_clk or negedge full_rstn) begin
    if (!full_rstn) begin
      data_word   <= '0;
      word_strobe <= 1'b0;
      word_count  <= '0;
    end else begin
      word_strobe <= data_last;
      if (data_last) begin
        data_word <= data_new;
        if (word_count != {WORD_CNT_W{1'b1}}) word_count <= word_count + WORD_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spi_ch_reg_decoder.sv
// Bench for spi_ch_reg_decoder: three configurations driven by one bit
// stream, each compared every cycle against a stream-level reference model.
module tb_spi_ch_reg_decoder;

  localparam int AW       = 7;
  localparam int DW       = 8;
  localparam int START    = 12;
  localparam int RPC      = 7;
  localparam int NCH      = 8;
  localparam int STOP     = START + NCH * RPC - 1;
  localparam int REG_NONE = 7;

  typedef struct packed {
    int addr;
    int ch;
    int rs;
    int inr;
    int data;
    int stb;
    int cnt;
  } exp_t;

  logic spi_clk   = 1'b0;
  logic full_rstn = 1'b0;
  logic mosi      = 1'b0;

  always #5 spi_clk = ~spi_clk;

  // inc: AUTO_INC=1 WRAP_CH=0 ; wrp: AUTO_INC=1 WRAP_CH=1 ; fix: AUTO_INC=0
  logic [6:0] a_addr, w_addr, n_addr;
  logic [2:0] a_ch, w_ch, n_ch;
  logic [2:0] a_reg, w_reg, n_reg;
  logic       a_inr, w_inr, n_inr;
  logic [7:0] a_data, w_data, n_data;
  logic       a_stb, w_stb, n_stb;
  logic [7:0] a_cnt, w_cnt, n_cnt;

  spi_ch_reg_decoder #(.AUTO_INC(1'b1), .WRAP_CH(1'b0)) dut_inc (
    .spi_clk(spi_clk), .full_rstn(full_rstn), .mosi(mosi),
    .addr_q(a_addr), .ch_sel(a_ch), .reg_sel(a_reg), .in_ch_range(a_inr),
    .data_word(a_data), .word_strobe(a_stb), .word_count(a_cnt)
  );

  spi_ch_reg_decoder #(.AUTO_INC(1'b1), .WRAP_CH(1'b1)) dut_wrp (
    .spi_clk(spi_clk), .full_rstn(full_rstn), .mosi(mosi),
    .addr_q(w_addr), .ch_sel(w_ch), .reg_sel(w_reg), .in_ch_range(w_inr),
    .data_word(w_data), .word_strobe(w_stb), .word_count(w_cnt)
  );

  spi_ch_reg_decoder #(.AUTO_INC(1'b0), .WRAP_CH(1'b0)) dut_fix (
    .spi_clk(spi_clk), .full_rstn(full_rstn), .mosi(mosi),
    .addr_q(n_addr), .ch_sel(n_ch), .reg_sel(n_reg), .in_ch_range(n_inr),
    .data_word(n_data), .word_strobe(n_stb), .word_count(n_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Every bit clocked in since the last reset, in arrival order.
  bit bits[$];

  always @(posedge spi_clk) if (full_rstn) bits.push_back(mosi);

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void decode(input int a, output int inr, output int ch, output int rs);
    if (a >= START && a <= STOP) begin
      inr = 1; ch = (a - START) / RPC; rs = (a - START) % RPC;
    end else begin
      inr = 0; ch = 0; rs = REG_NONE;
    end
  endfunction

  function automatic int next_addr(input int a, input bit ai, input bit wc);
    if (!ai) return a;
    if (wc && a >= START && a <= STOP && (a - START) % RPC == RPC - 1) return a - (RPC - 1);
    return (a + 1) % (1 << AW);
  endfunction

  // Expected outputs purely from the bit stream: first AW bits are the base
  // address, each further DW bits a word; the address steps once per word,
  // one cycle after that word's strobe.
  function automatic exp_t model(input bit ai, input bit wc);
    exp_t e;
    int n, m, w, k, a, d, inr, ch, rs;
    e = '{addr: 0, ch: 0, rs: REG_NONE, inr: 0, data: 0, stb: 0, cnt: 0};
    n = bits.size();
    if (n < AW) return e;
    a = 0;
    for (int i = 0; i < AW; i++) a = a * 2 + int'(bits[i]);
    m = n - AW;
    w = m / DW;
    e.stb = (w > 0 && m % DW == 0) ? 1 : 0;
    k = (e.stb != 0) ? w - 1 : w;
    for (int j = 0; j < k; j++) a = next_addr(a, ai, wc);
    decode(a, inr, ch, rs);
    e.addr = a; e.inr = inr; e.ch = ch; e.rs = rs;
    d = 0;
    if (w > 0) for (int i = 0; i < DW; i++) d = d * 2 + int'(bits[AW + (w - 1) * DW + i]);
    e.data = d;
    e.cnt = (w > 255) ? 255 : w;
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input int addr, input int ch,
                     input int rs, input int inr, input int data, input int stb, input int cnt);
    check({tag, ".addr_q"},      addr, e.addr);
    check({tag, ".ch_sel"},      ch,   e.ch);
    check({tag, ".reg_sel"},     rs,   e.rs);
    check({tag, ".in_ch_range"}, inr,  e.inr);
    check({tag, ".data_word"},   data, e.data);
    check({tag, ".word_strobe"}, stb,  e.stb);
    check({tag, ".word_count"},  cnt,  e.cnt);
  endtask

  // Per-cycle comparison of all three configurations against the model.
  always @(negedge spi_clk) begin
    cmp("inc", model(1'b1, 1'b0), int'(a_addr), int'(a_ch), int'(a_reg), int'(a_inr),
        int'(a_data), int'(a_stb), int'(a_cnt));
    cmp("wrp", model(1'b1, 1'b1), int'(w_addr), int'(w_ch), int'(w_reg), int'(w_inr),
        int'(w_data), int'(w_stb), int'(w_cnt));
    cmp("fix", model(1'b0, 1'b0), int'(n_addr), int'(n_ch), int'(n_reg), int'(n_inr),
        int'(n_data), int'(n_stb), int'(n_cnt));
  end

  // Reset spanning one posedge; returns aligned on a negedge.
  task automatic do_reset();
    @(posedge spi_clk);
    #1 full_rstn = 1'b0;
    bits.delete();
    @(posedge spi_clk);
    #1 full_rstn = 1'b1;
    @(negedge spi_clk);
  endtask

  // Drive nb bits of val MSB first, one per clock; returns on a negedge.
  task automatic send_bits(input int val, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      mosi = val[i];
      @(posedge spi_clk);
      @(negedge spi_clk);
    end
  endtask

  initial begin
    int bnd[12];
    int addr, nbytes;
    bnd = '{11, 12, 17, 18, 19, 54, 60, 66, 67, 68, 127, 0};

    // 1: address 12, byte 0xA5
    do_reset();
    check("rst.addr_q", int'(a_addr), 0);
    check("rst.reg_sel", int'(a_reg), REG_NONE);
    check("rst.in_ch_range", int'(a_inr), 0);
    send_bits(12, AW);
    check("t1.addr_q", int'(a_addr), 12);
    check("t1.ch_sel", int'(a_ch), 0);
    check("t1.reg_sel", int'(a_reg), 0);
    check("t1.in_ch_range", int'(a_inr), 1);
    send_bits(8'hA5, DW);
    check("t1.data_word", int'(a_data), 8'hA5);
    check("t1.word_strobe", int'(a_stb), 1);
    check("t1.word_count", int'(a_cnt), 1);
    send_bits(0, 1);
    check("t1.strobe_drop", int'(a_stb), 0);
    check("t1.addr_inc", int'(a_addr), 13);

    // 2: window edges
    do_reset();
    send_bits(67, AW);
    check("t2.67.ch_sel", int'(a_ch), 7);
    check("t2.67.reg_sel", int'(a_reg), 6);
    check("t2.67.in_ch_range", int'(a_inr), 1);
    do_reset();
    send_bits(11, AW);
    check("t2.11.in_ch_range", int'(a_inr), 0);
    check("t2.11.reg_sel", int'(a_reg), REG_NONE);
    do_reset();
    send_bits(68, AW);
    check("t2.68.in_ch_range", int'(a_inr), 0);
    check("t2.68.reg_sel", int'(a_reg), REG_NONE);
    check("t2.68.ch_sel", int'(a_ch), 0);

    // 3/4: burst from 18 under each increment mode
    do_reset();
    send_bits(18, AW);
    send_bits(8'h11, DW);
    check("t3.s1.addr_q", int'(a_addr), 18);
    check("t3.s1.reg_sel", int'(a_reg), 6);
    check("t3.s1.data_word", int'(a_data), 8'h11);
    send_bits(8'h22, DW);
    check("t3.s2.word_strobe", int'(a_stb), 1);
    check("t3.s2.addr_q", int'(a_addr), 19);
    check("t3.s2.ch_sel", int'(a_ch), 1);
    check("t3.s2.reg_sel", int'(a_reg), 0);
    check("t3.s2.data_word", int'(a_data), 8'h22);
    check("t4.wrap.addr_q", int'(w_addr), 12);
    check("t4.wrap.ch_sel", int'(w_ch), 0);
    check("t4.wrap.reg_sel", int'(w_reg), 0);
    check("t4.fix.addr_q", int'(n_addr), 18);

    // 5: address-space wrap, then counter saturation
    do_reset();
    send_bits(127, AW);
    send_bits(8'h3C, DW);
    send_bits(8'hC3, DW);
    check("t5.addr_q", int'(a_addr), 0);
    check("t5.in_ch_range", int'(a_inr), 0);
    check("t5.wrap_cfg.addr_q", int'(w_addr), 0);
    do_reset();
    send_bits(int'($urandom_range(0, 127)), AW);
    for (int i = 0; i < 260; i++) send_bits(int'($urandom_range(0, 255)), DW);
    check("t5.sat.word_count", int'(a_cnt), 255);
    check("t5.sat.fix.word_count", int'(n_cnt), 255);

    // 6: reset mid data word
    do_reset();
    send_bits(20, AW);
    send_bits(3'b101, 3);
    #1 full_rstn = 1'b0;
    bits.delete();
    #1;
    check("t6.addr_q", int'(a_addr), 0);
    check("t6.reg_sel", int'(a_reg), REG_NONE);
    check("t6.word_strobe", int'(a_stb), 0);
    check("t6.data_word", int'(a_data), 0);
    @(posedge spi_clk);
    #1 full_rstn = 1'b1;
    @(negedge spi_clk);
    send_bits(40, AW);
    check("t6.40.ch_sel", int'(a_ch), 4);
    check("t6.40.reg_sel", int'(a_reg), 0);
    check("t6.40.in_ch_range", int'(a_inr), 1);

    // Random transactions, often near window/channel boundaries, some with
    // a trailing partial word that the next reset discards.
    for (int t = 0; t < 12; t++) begin
      do_reset();
      addr = ($urandom_range(0, 1) == 1) ? bnd[$urandom_range(0, 11)] : int'($urandom_range(0, 127));
      send_bits(addr, AW);
      nbytes = int'($urandom_range(1, 12));
      for (int b = 0; b < nbytes; b++) send_bits(int'($urandom_range(0, 255)), DW);
      send_bits(int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
    end

    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
